icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch stage's fetch-packet requests. Each hit returns one 64-bit packet (two 32-bit instructions, lower address in bits [31:0]) one cycle after acceptance. A miss stalls fetch while the line is refilled from a 64-bit beat-based memory port. The block sits between fetch and the memory arbiter and uses `uarch_pkg` widths (CPU_ADDR_BITS=32, CPU_INST_BITS=32).

---
 rtl/icache.sv | 130 +++++++++++++
 tb/tb_icache.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped read-only fetch cache; a hit returns a 64-bit packet one cycle after accept.
// A miss holds icache_stall high until the refill ends; mem_req_val holds with a stable address until mem_req_rdy.
module icache #(
   parameter int NUM_LINES     = 64,
   parameter int LINE_BEATS    = 2,
   parameter int CPU_ADDR_BITS = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       inv,
   input  logic [CPU_ADDR_BITS-1:0]   icache_addr,
   input  logic                       icache_re,
   output logic                       icache_stall,
   output logic [2*CPU_ADDR_BITS-1:0] icache_dout,
   output logic                       icache_dout_val,
   output logic                       mem_req_val,
   input  logic                       mem_req_rdy,
   output logic [CPU_ADDR_BITS-1:0]   mem_req_addr,
   input  logic                       mem_resp_val,
   input  logic [63:0]                mem_resp_data
);
   localparam int INDEX_BITS    = $clog2(NUM_LINES);
   localparam int BEAT_BITS     = $clog2(LINE_BEATS);
   localparam int OFFSET_BITS   = 3 + BEAT_BITS;
   localparam int TAG_BITS      = CPU_ADDR_BITS - OFFSET_BITS - INDEX_BITS;
   localparam int DATA_IDX_BITS = INDEX_BITS + BEAT_BITS;
   localparam int DATA_DEPTH    = NUM_LINES * LINE_BEATS;
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);
   localparam logic [CPU_ADDR_BITS-1:0] LINE_MASK =
      {{(CPU_ADDR_BITS - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;

   state_t                     state_q, state_d;
   logic [NUM_LINES-1:0]       valid_q, valid_d;
   logic [TAG_BITS-1:0]        tag_q [NUM_LINES];
   logic [TAG_BITS-1:0]        tag_d [NUM_LINES];
   logic [CPU_ADDR_BITS-1:0]   fill_addr_q, fill_addr_d;
   logic [BEAT_BITS-1:0]       beat_cnt_q, beat_cnt_d;
   logic [63:0]                dout_q, dout_d;
   logic                       dout_val_q, dout_val_d;
   logic [63:0]                data_mem [DATA_DEPTH];

   logic [INDEX_BITS-1:0]      idx, fill_idx;
   logic [TAG_BITS-1:0]        addr_tag, fill_tag;
   logic [BEAT_BITS-1:0]       beat_sel;
   logic [DATA_IDX_BITS-1:0]   raddr, waddr;
   logic                       hit, accept, mem_we;

   assign idx      = icache_addr[OFFSET_BITS +: INDEX_BITS];
   assign addr_tag = icache_addr[CPU_ADDR_BITS-1 -: TAG_BITS];
   assign beat_sel = icache_addr[3 +: BEAT_BITS];
   assign fill_idx = fill_addr_q[OFFSET_BITS +: INDEX_BITS];
   assign fill_tag = fill_addr_q[CPU_ADDR_BITS-1 -: TAG_BITS];
   assign raddr    = {idx, beat_sel};
   assign waddr    = {fill_idx, beat_cnt_q};

   // Stall comes only from state and lookup, never from icache_re, to avoid a loop through fetch.
   assign hit          = valid_q[idx] && (tag_q[idx] == addr_tag);
   assign icache_stall = (state_q != IDLE) || !hit;
   assign accept       = icache_re && !icache_stall;
   assign mem_we       = (state_q == REFILL) && mem_resp_val;

   assign mem_req_val     = (state_q == REQ);
   assign mem_req_addr    = fill_addr_q;
   assign icache_dout     = dout_q;
   assign icache_dout_val = dout_val_q;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      fill_addr_d = fill_addr_q;
      beat_cnt_d  = beat_cnt_q;
      dout_val_d  = accept && !flush;
      dout_d      = (accept && !flush) ? data_mem[raddr] : dout_q;
      case (state_q)
         IDLE: begin
            if (!hit) begin
               fill_addr_d = icache_addr & LINE_MASK;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (mem_req_rdy) begin
               beat_cnt_d = '0;
               state_d    = REFILL;
            end
         end
         REFILL: begin
            if (mem_resp_val) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  tag_d[fill_idx]   = fill_tag;
                  valid_d[fill_idx] = 1'b1;
                  state_d           = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Invalidate wins over an install landing in the same cycle.
      if (inv) valid_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         tag_q       <= '{default: '0};
         fill_addr_q <= '0;
         beat_cnt_q  <= '0;
         dout_q      <= '0;
         dout_val_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         fill_addr_q <= fill_addr_d;
         beat_cnt_q  <= beat_cnt_d;
         dout_q      <= dout_d;
         dout_val_q  <= dout_val_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) data_mem[waddr] <= mem_resp_data;
   end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: transaction-level cache model with per-cycle output comparison,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_icache;
   localparam int NUM_LINES  = 64;
   localparam int LINE_BEATS = 2;
   localparam int LINE_BYTES = LINE_BEATS * 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        inv = 1'b0;
   logic [31:0] icache_addr = '0;
   logic        icache_re = 1'b0;
   logic        mem_req_rdy = 1'b0;
   logic        mem_resp_val = 1'b0;
   logic [63:0] mem_resp_data = '0;
   logic        icache_stall, icache_dout_val, mem_req_val;
   logic [63:0] icache_dout;
   logic [31:0] mem_req_addr;

   always #5 clk = ~clk;

   icache #(.NUM_LINES(NUM_LINES), .LINE_BEATS(LINE_BEATS), .CPU_ADDR_BITS(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .inv(inv),
      .icache_addr(icache_addr), .icache_re(icache_re), .icache_stall(icache_stall),
      .icache_dout(icache_dout), .icache_dout_val(icache_dout_val),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
      .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data)
   );

   int total = 0;
   int bad = 0;

   // Model: which line address each slot holds, plus the one outstanding refill.
   bit          m_vld [NUM_LINES];
   logic [31:0] m_line [NUM_LINES];
   bit          m_pend = 0;
   bit          m_fill = 0;
   logic [31:0] m_pline = '0;
   int          m_got = 0;
   bit          m_dval = 0;
   logic [63:0] m_dout = '0;
   int          p_rdy = 0;
   int          p_resp = 0;

   function automatic logic [31:0] line_of(logic [31:0] a);
      return a - (a % LINE_BYTES);
   endfunction

   function automatic int idx_of(logic [31:0] a);
      return int'((a / LINE_BYTES) % NUM_LINES);
   endfunction

   function automatic bit resident(logic [31:0] a);
      return m_vld[idx_of(a)] && (m_line[idx_of(a)] == line_of(a));
   endfunction

   // Memory contents: each 32-bit word holds its own address tagged with C0DE.
   function automatic logic [63:0] pkt(logic [31:0] a);
      logic [31:0] b;
      b = a - (a % 8);
      return {(b + 32'd4) ^ 32'hC0DE_0000, b ^ 32'hC0DE_0000};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            foreach (m_vld[i]) m_vld[i] = 0;
            m_pend = 0; m_fill = 0; m_got = 0; m_dval = 0; m_dout = '0;
         end else begin
            bit stall_now;
            bit acc;
            stall_now = m_pend || !resident(icache_addr);
            acc = icache_re && !stall_now;
            m_dval = acc && !flush;
            if (acc && !flush) m_dout = pkt(icache_addr);
            if (!m_pend) begin
               if (!resident(icache_addr)) begin
                  m_pend = 1; m_fill = 0; m_pline = line_of(icache_addr);
               end
            end else if (!m_fill) begin
               if (mem_req_rdy) begin m_fill = 1; m_got = 0; end
            end else if (mem_resp_val) begin
               m_got++;
               if (m_got == LINE_BEATS) begin
                  m_vld[idx_of(m_pline)] = 1;
                  m_line[idx_of(m_pline)] = m_pline;
                  m_pend = 0; m_fill = 0;
               end
            end
            if (inv) foreach (m_vld[i]) m_vld[i] = 0;
         end
      end
   end

   // Memory side: random ready/beat timing; beat data follows the line being filled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_req_rdy   = ($urandom_range(0, 99) < p_rdy);
         mem_resp_val  = ($urandom_range(0, 99) < p_resp);
         mem_resp_data = m_fill ? pkt(m_pline + 32'(8 * m_got)) : {$urandom, $urandom};
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("stall", icache_stall, m_pend || !resident(icache_addr));
         chk("dout_val", icache_dout_val, m_dval);
         chk("dout", icache_dout, m_dout);
         chk("req_val", mem_req_val, m_pend && !m_fill);
         if (m_pend && !m_fill) chk("req_addr", mem_req_addr, m_pline);
      end
   end

   task automatic wait_req(int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (!mem_req_val && n < budget);
   endtask

   task automatic wait_ready(int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (icache_stall && n < budget);
   endtask

   initial begin
      int n;
      logic [31:0] pool [8];
      pool = '{32'h0000_1000, 32'h0000_1400, 32'h0000_1010, 32'h0000_2040,
               32'h0000_2440, 32'hFFFF_FFF0, 32'h0000_0000, 32'h8000_1000};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", icache_stall, 1);
      chk("reset_req_val", mem_req_val, 0);
      chk("reset_dout", icache_dout, 64'h0);

      // Cold miss then streaming hits
      @(posedge clk); #1;
      rst = 0; icache_addr = 32'h1000; icache_re = 1; p_rdy = 100; p_resp = 100;
      wait_req(20);
      chk("cold_req_val", mem_req_val, 1);
      chk("cold_req_addr", mem_req_addr, 32'h1000);
      chk("cold_stall", icache_stall, 1);
      wait_ready(30);
      chk("cold_fill_done", icache_stall, 0);
      @(posedge clk); #1;
      icache_addr = 32'h1008;
      @(negedge clk);
      chk("stream0_val", icache_dout_val, 1);
      chk("stream0_dout", icache_dout, 64'hC0DE_1004_C0DE_1000);
      @(posedge clk); #1;
      icache_re = 0;
      @(negedge clk);
      chk("stream1_val", icache_dout_val, 1);
      chk("stream1_dout", icache_dout, 64'hC0DE_100C_C0DE_1008);
      chk("stream_no_req", mem_req_val, 0);

      // Request backpressure
      @(posedge clk); #1;
      p_rdy = 0; icache_addr = 32'h2040; icache_re = 1;
      wait_req(10);
      for (int i = 0; i < 6; i++) begin
         chk("bp_req_val", mem_req_val, 1);
         chk("bp_req_addr", mem_req_addr, 32'h2040);
         chk("bp_stall", icache_stall, 1);
         if (i < 5) @(negedge clk);
      end
      p_rdy = 100;
      n = 0;
      do begin @(negedge clk); n++; end while (!icache_dout_val && n < 30);
      chk("bp_dout_val", icache_dout_val, 1);
      chk("bp_dout", icache_dout, 64'hC0DE_2044_C0DE_2040);

      // Flush cancels the response
      @(posedge clk); #1;
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      @(negedge clk);
      chk("flush_val", icache_dout_val, 0);

      // Conflict replacement, then invalidate
      @(posedge clk); #1;
      icache_addr = 32'h1000 + NUM_LINES * 16;
      wait_req(10);
      chk("conf_req_addr", mem_req_addr, 32'h1400);
      wait_ready(30);
      @(posedge clk); #1;
      icache_addr = 32'h1000;
      @(negedge clk);
      chk("conf_evicted_stall", icache_stall, 1);
      wait_req(10);
      chk("conf_refetch_addr", mem_req_addr, 32'h1000);
      wait_ready(30);
      chk("conf_refetch_done", icache_stall, 0);
      @(posedge clk); #1;
      inv = 1;
      @(posedge clk); #1;
      inv = 0;
      @(negedge clk);
      chk("inv_stall", icache_stall, 1);
      @(negedge clk);
      chk("inv_req_val", mem_req_val, 1);
      chk("inv_req_addr", mem_req_addr, 32'h1000);
      wait_ready(30);

      // Reset after the first beat of a refill
      @(posedge clk); #1;
      icache_addr = 32'h3000; p_resp = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_fill && n < 10);
      p_resp = 100;
      n = 0;
      do begin @(negedge clk); n++; end while (m_got != 1 && n < 10);
      chk("rst_wait_beat0", (m_got == 1), 1);
      #2;
      rst = 1; p_rdy = 0;
      @(negedge clk);
      chk("rst_dout_val", icache_dout_val, 0);
      chk("rst_req_val", mem_req_val, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rst_reaccess_stall", icache_stall, 1);
      @(negedge clk);
      chk("rst_reaccess_req", mem_req_val, 1);
      chk("rst_reaccess_addr", mem_req_addr, 32'h3000);
      p_rdy = 100;
      wait_ready(30);
      chk("rst_refill_done", icache_stall, 0);

      // Randomized traffic
      p_rdy = 60; p_resp = 60;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         icache_addr = pool[$urandom_range(0, 7)] + 32'(8 * $urandom_range(0, LINE_BEATS - 1))
                       + 32'($urandom_range(0, 7));
         icache_re = ($urandom_range(0, 99) < 80);
         flush     = ($urandom_range(0, 99) < 10);
         inv       = ($urandom_range(0, 99) < 2);
         rst       = ($urandom_range(0, 199) == 0);
      end
      @(posedge clk); #1;
      rst = 0; flush = 0; inv = 0; icache_re = 0;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
